// File: rtl/seq_pkg.sv
// Shared types and helpers for the frame scheduler and its pattern matcher.
package seq_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Default pattern: the first received bit is the MSB.
  localparam int                   DEF_PAT_W   = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b11011;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// Bit-serial pattern window: shifts one bit per enabled cycle, tracks how many
// bits have entered since the last clear, and flags a match combinationally
// for the bit being shifted in this cycle. Overlapping matches are reported.
module seq_window_match
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  // Seen-bit counter saturates at PAT_W; only "full window" matters.
  localparam int SW = width_of(PAT_W + 1);

  logic [PAT_W-1:0] window_q;
  logic [PAT_W-1:0] window_next;
  logic [SW-1:0]    seen_q;
  logic [SW-1:0]    seen_next;

  // Next window/count and match test against the updated window.
  always_comb begin
    window_next = {window_q[PAT_W-2:0], bit_in};
    seen_next   = (seen_q == SW'(PAT_W)) ? seen_q : seen_q + 1'b1;
    match       = shift_en && (window_next == PATTERN) && (seen_next == SW'(PAT_W));
  end

  // Window and seen count; cleared at each grant so frames never share bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      window_q <= '0;
      seen_q   <= '0;
    end else if (clear) begin
      window_q <= '0;
      seen_q   <= '0;
    end else if (shift_en) begin
      window_q <= window_next;
      seen_q   <= seen_next;
    end
  end

endmodule

// File: rtl/seq_frame_scheduler.sv
// Round-robin scheduler that time-shares one serial pattern detector among
// N_REQ requesters. A granted frame is latched, shifted MSB-first through the
// detector, and its saturating match count is reported with a done pulse.
//
// Handshake: req[i] is a level request. The scheduler answers with a one-hot
// gnt that stays high from the first shift cycle through the report cycle;
// frame_data slice i is captured only on the edge that raises gnt[i], so the
// producer may change it or drop req[i] at any time after that edge. A request
// seen while busy simply waits until the scheduler is idle again.
module seq_frame_scheduler
  import seq_pkg::*;
#(
  parameter int               N_REQ     = 4,
  parameter int               FRAME_LEN = 16,
  parameter int               PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W     = 5,
  parameter int               IDW       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_LEN-1:0] frame_data,
  output logic [N_REQ-1:0]           gnt,
  output logic                       busy,
  output logic                       hit,
  output logic                       done,
  output logic [IDW-1:0]             done_id,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [1:0]                 state_dbg
);

  localparam int                 BCW      = width_of(FRAME_LEN);
  localparam logic [BCW-1:0]     LAST_BIT = BCW'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
  localparam logic [N_REQ-1:0]   GNT_ONE  = N_REQ'(1);

  state_t               state;
  logic [IDW-1:0]       last_gnt;
  logic [IDW-1:0]       cur_id;
  logic [FRAME_LEN-1:0] frame_q;
  logic [BCW-1:0]       bit_cnt;
  logic [CNT_W-1:0]     cnt_q;

  logic                 pick_valid;
  logic [IDW-1:0]       pick_idx;
  logic [FRAME_LEN-1:0] pick_frame;
  logic [CNT_W-1:0]     cnt_next;
  logic                 win_clear;
  logic                 win_shift;
  logic                 win_match;

  assign state_dbg = state;

  // Round-robin pick: first set request at or after last_gnt+1, wrapping.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      int cand;
      cand = (int'(last_gnt) + i) % N_REQ;
      if (!pick_valid && req[IDW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IDW'(cand);
      end
    end
  end

  // Frame slice of the picked requester.
  always_comb begin
    pick_frame = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDW'(i)) pick_frame = frame_data[i*FRAME_LEN +: FRAME_LEN];
    end
  end

  // Detector controls and saturating match counter increment.
  always_comb begin
    win_clear = (state == IDLE) && pick_valid;
    win_shift = (state == SHIFT);
    cnt_next  = (win_match && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end

  seq_window_match #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_match (
    .clk      (clk),
    .rstn     (rstn),
    .clear    (win_clear),
    .shift_en (win_shift),
    .bit_in   (frame_q[FRAME_LEN-1]),
    .match    (win_match)
  );

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      hit       <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      match_cnt <= '0;
      bit_cnt   <= '0;
      frame_q   <= '0;
      cnt_q     <= '0;
      cur_id    <= '0;
      last_gnt  <= IDW'(N_REQ - 1);
    end else begin
      hit  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt      <= GNT_ONE << pick_idx;
            busy     <= 1'b1;
            frame_q  <= pick_frame;
            bit_cnt  <= '0;
            cnt_q    <= '0;
            cur_id   <= pick_idx;
            last_gnt <= pick_idx;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          frame_q <= frame_q << 1;
          hit     <= win_match;
          cnt_q   <= cnt_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            done      <= 1'b1;
            done_id   <= cur_id;
            match_cnt <= cnt_next;
            state     <= REPORT;
          end
        end
        REPORT: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_scheduler.sv
// Bench for seq_frame_scheduler: directed scenarios plus randomized
// back-to-back frames, checked against a substring-count reference model.
module tb_seq_frame_scheduler;

  localparam int            N   = 4;
  localparam int            F   = 16;
  localparam int            PW  = 5;
  localparam int            CW  = 5;
  localparam int            CWS = 2;
  localparam logic [PW-1:0] PAT = 5'b11011;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*F-1:0] frame_data = '0;

  logic [N-1:0]   gnt, gnt_s;
  logic           busy, busy_s, hit, hit_s, done, done_s;
  logic [1:0]     done_id, done_id_s;
  logic [CW-1:0]  match_cnt;
  logic [CWS-1:0] match_cnt_s;
  logic [1:0]     state_dbg, state_dbg_s;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int model_last = N - 1;

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_frame_scheduler #(.N_REQ(N), .FRAME_LEN(F), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .frame_data(frame_data),
    .gnt(gnt), .busy(busy), .hit(hit), .done(done), .done_id(done_id),
    .match_cnt(match_cnt), .state_dbg(state_dbg)
  );

  seq_frame_scheduler #(.N_REQ(N), .FRAME_LEN(F), .CNT_W(CWS)) dut_sat (
    .clk(clk), .rstn(rstn), .req(req), .frame_data(frame_data),
    .gnt(gnt_s), .busy(busy_s), .hit(hit_s), .done(done_s), .done_id(done_id_s),
    .match_cnt(match_cnt_s), .state_dbg(state_dbg_s)
  );

  // Reference model: count every (overlapping) occurrence of PAT in the frame
  function automatic int model_count(input logic [F-1:0] f);
    int c = 0;
    for (int p = 0; p <= F - PW; p++)
      if (f[F-1-p -: PW] == PAT) c++;
    return c;
  endfunction

  // Hit cycles relative to the first granted cycle: match ending at bit e -> cycle e+1
  function automatic logic [31:0] model_hits(input logic [F-1:0] f);
    logic [31:0] m = '0;
    for (int p = 0; p <= F - PW; p++)
      if (f[F-1-p -: PW] == PAT) m[p+PW] = 1'b1;
    return m;
  endfunction

  function automatic int model_sat(input int c, input int w);
    int mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Driver tasks
  task automatic set_frame(input int i, input logic [F-1:0] v);
    frame_data[i*F +: F] = v;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Observe one frame from grant to done (bounded); no comparisons here
  task automatic collect(input bit scramble, output logic [N-1:0] g, output bit bsy,
                         output logic [31:0] hm, output int da, output logic [1:0] did,
                         output logic [CW-1:0] mc, output logic [CWS-1:0] mcs,
                         output int ga, output bit ok);
    int start;
    start = -1; g = '0; bsy = 1'b0; hm = '0; da = -1; did = '0; mc = '0; mcs = '0;
    ga = -1; ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (start < 0 && gnt != '0) begin
        start = cyc; g = gnt; bsy = busy; ga = cyc;
        if (scramble) begin
          frame_data = {$urandom, $urandom};
          req = '0;
        end
      end
      if (start >= 0 && hit && (cyc - start) < 32) hm[cyc-start] = 1'b1;
      if (done) begin
        da = (start >= 0) ? cyc - start : -1;
        did = done_id; mc = match_cnt; mcs = match_cnt_s; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req = 4'($urandom_range(1, 15));
      frame_data = {$urandom, $urandom};
      step(1);
      n_checks++;
      if ({gnt, busy, hit, done, done_id, match_cnt, match_cnt_s} !== '0)
        $display("FAIL reset_outputs: gnt=%b busy=%b hit=%b done=%b id=%0d cnt=%0d cnt_s=%0d, want all 0",
                 gnt, busy, hit, done, done_id, match_cnt, match_cnt_s);
      else n_pass++;
    end
    req = '0;
    rstn = 1'b1;
    model_last = N - 1;
    step(2);
    n_checks++;
    if (gnt !== '0 || busy !== 1'b0) $display("FAIL idle_no_req: gnt=%b busy=%b, want 0 0", gnt, busy);
    else n_pass++;
  endtask

  task automatic test_single;
    logic [N-1:0] g; bit bsy, ok; logic [31:0] hm; int da, ga;
    logic [1:0] did; logic [CW-1:0] mc; logic [CWS-1:0] mcs;
    set_frame(0, 16'hDB00);
    req = 4'b0001;
    collect(1'b0, g, bsy, hm, da, did, mc, mcs, ga, ok);
    req = '0;
    model_last = 0;
    n_checks++; if (!ok) $display("FAIL single_timeout: done seen=%0d, want 1", ok); else n_pass++;
    n_checks++; if (g !== 4'b0001 || bsy !== 1'b1) $display("FAIL single_gnt: gnt=%b busy=%b, want 0001 1", g, bsy); else n_pass++;
    n_checks++; if (hm !== 32'h120) $display("FAIL single_hits: hit cycles=%h, want 120", hm); else n_pass++;
    n_checks++; if (da !== F) $display("FAIL single_done_lat: done at %0d, want %0d", da, F); else n_pass++;
    n_checks++; if (did !== 2'd0 || mc !== 5'd2) $display("FAIL single_result: id=%0d cnt=%0d, want 0 2", did, mc); else n_pass++;
    step(2);
    n_checks++; if (gnt !== '0 || busy !== 1'b0) $display("FAIL single_release: gnt=%b busy=%b, want 0 0", gnt, busy); else n_pass++;
  endtask

  task automatic test_overlap;
    logic [N-1:0] g; bit bsy, ok; logic [31:0] hm; int da, ga;
    logic [1:0] did; logic [CW-1:0] mc; logic [CWS-1:0] mcs;
    // frame_data scrambled and req dropped right after the grant edge
    set_frame(0, 16'hDB6D);
    req = 4'b0001;
    collect(1'b1, g, bsy, hm, da, did, mc, mcs, ga, ok);
    model_last = 0;
    n_checks++; if (!ok || mc !== 5'd4) $display("FAIL overlap_cnt: ok=%0d cnt=%0d, want 1 4", ok, mc); else n_pass++;
    n_checks++; if (mcs !== 2'd3) $display("FAIL overlap_sat: cnt=%0d, want 3", mcs); else n_pass++;
    n_checks++; if (hm !== model_hits(16'hDB6D)) $display("FAIL overlap_hits: hits=%h, want %h", hm, model_hits(16'hDB6D)); else n_pass++;
    step(3);
    n_checks++; if (gnt !== '0) $display("FAIL dropped_req_regrant: gnt=%b, want 0", gnt); else n_pass++;
    set_frame(0, 16'hFFFF);
    req = 4'b0001;
    collect(1'b0, g, bsy, hm, da, did, mc, mcs, ga, ok);
    req = '0;
    n_checks++; if (!ok || mc !== 5'd0 || hm !== 32'h0) $display("FAIL ones_cnt: ok=%0d cnt=%0d hits=%h, want 1 0 0", ok, mc, hm); else n_pass++;
    step(2);
  endtask

  task automatic test_round_robin;
    logic [N-1:0] g; bit bsy, ok; logic [31:0] hm; int da, ga, prev_ga;
    logic [1:0] did; logic [CW-1:0] mc; logic [CWS-1:0] mcs; logic [F-1:0] f;
    int exp_id;
    rstn = 1'b0; step(2); rstn = 1'b1; model_last = N - 1;
    for (int i = 0; i < N; i++) set_frame(i, 16'($urandom));
    req = 4'b1111;
    prev_ga = -1;
    for (int k = 0; k < 5; k++) begin
      exp_id = model_pick(req, model_last);
      f = frame_data[exp_id*F +: F];
      collect(1'b0, g, bsy, hm, da, did, mc, mcs, ga, ok);
      n_checks++;
      if (!ok || g !== 4'(1 << exp_id) || did !== 2'(exp_id))
        $display("FAIL rr_order[%0d]: ok=%0d gnt=%b id=%0d, want id %0d", k, ok, g, did, exp_id);
      else n_pass++;
      n_checks++;
      if (mc !== 5'(model_sat(model_count(f), CW)))
        $display("FAIL rr_cnt[%0d]: cnt=%0d, want %0d", k, mc, model_count(f));
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (ga - prev_ga != F + 2) $display("FAIL rr_spacing[%0d]: %0d cycles, want %0d", k, ga - prev_ga, F + 2);
        else n_pass++;
      end
      prev_ga = ga;
      model_last = exp_id;
    end
    req = '0;
    step(2);
  endtask

  task automatic test_cross_frame;
    logic [N-1:0] g; bit bsy, ok; logic [31:0] hm; int da, ga;
    logic [1:0] did; logic [CW-1:0] mc; logic [CWS-1:0] mcs;
    int exp_id;
    set_frame(0, 16'h000D);
    set_frame(1, 16'hB000);
    req = 4'b0011;
    for (int k = 0; k < 2; k++) begin
      exp_id = model_pick(req, model_last);
      collect(1'b0, g, bsy, hm, da, did, mc, mcs, ga, ok);
      n_checks++;
      if (!ok || did !== 2'(exp_id) || mc !== 5'd0 || hm !== 32'h0)
        $display("FAIL cross_frame[%0d]: ok=%0d id=%0d cnt=%0d hits=%h, want id %0d cnt 0",
                 k, ok, did, mc, hm, exp_id);
      else n_pass++;
      model_last = exp_id;
    end
    req = '0;
    step(2);
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] g; bit bsy, ok; logic [31:0] hm; int da, ga, prev_ga;
    logic [1:0] did; logic [CW-1:0] mc; logic [CWS-1:0] mcs; logic [F-1:0] f;
    logic [F-1:0] pool [6];
    int exp_id, c;
    pool = '{16'hDB6D, 16'hB6DB, 16'h6DB6, 16'hDB00, 16'h1B1B, 16'hFFFF};
    prev_ga = -1;
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < N; i++)
        set_frame(i, ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 5)] : 16'($urandom));
      req = 4'($urandom_range(1, 15));
      exp_id = model_pick(req, model_last);
      f = frame_data[exp_id*F +: F];
      c = model_count(f);
      collect(1'b0, g, bsy, hm, da, did, mc, mcs, ga, ok);
      n_checks++;
      if (!ok || g !== 4'(1 << exp_id) || did !== 2'(exp_id) || da !== F)
        $display("FAIL b2b_grant[%0d]: ok=%0d gnt=%b id=%0d done_at=%0d, want id %0d at %0d",
                 it, ok, g, did, da, exp_id, F);
      else n_pass++;
      n_checks++;
      if (mc !== 5'(model_sat(c, CW)) || mcs !== 2'(model_sat(c, CWS)))
        $display("FAIL b2b_cnt[%0d]: cnt=%0d cnt_s=%0d, want %0d %0d", it, mc, mcs,
                 model_sat(c, CW), model_sat(c, CWS));
      else n_pass++;
      n_checks++;
      if (hm !== model_hits(f)) $display("FAIL b2b_hits[%0d]: hits=%h, want %h", it, hm, model_hits(f));
      else n_pass++;
      if (it > 0) begin
        n_checks++;
        if (ga - prev_ga != F + 2) $display("FAIL b2b_spacing[%0d]: %0d cycles, want %0d", it, ga - prev_ga, F + 2);
        else n_pass++;
      end
      prev_ga = ga;
      model_last = exp_id;
    end
    req = '0;
    step(3);
  endtask

  task automatic test_abort_reset;
    logic [N-1:0] g; bit bsy, ok, seen; logic [31:0] hm; int da, ga;
    logic [1:0] did; logic [CW-1:0] mc; logic [CWS-1:0] mcs;
    set_frame(0, 16'hDB00);
    req = 4'b0001;
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      step(1);
      if (gnt != '0) seen = 1'b1;
    end
    n_checks++; if (gnt !== 4'b0001) $display("FAIL abort_grant: gnt=%b, want 0001", gnt); else n_pass++;
    seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step(1);
      if (done) seen = 1'b1;
    end
    // now in shift cycle 7: reset mid-frame
    rstn = 1'b0;
    req = 4'b0100;
    set_frame(2, 16'hDB6D);
    step(1);
    if (done) seen = 1'b1;
    n_checks++;
    if ({gnt, busy, hit, done, done_id, match_cnt} !== '0 || seen)
      $display("FAIL abort_outputs: gnt=%b busy=%b hit=%b done=%b id=%0d cnt=%0d done_seen=%0d, want all 0",
               gnt, busy, hit, done, done_id, match_cnt, seen);
    else n_pass++;
    rstn = 1'b1;
    model_last = N - 1;
    collect(1'b0, g, bsy, hm, da, did, mc, mcs, ga, ok);
    req = '0;
    n_checks++;
    if (!ok || g !== 4'b0100 || did !== 2'd2 || mc !== 5'd4 || mcs !== 2'd3 || da !== F)
      $display("FAIL abort_next_frame: ok=%0d gnt=%b id=%0d cnt=%0d cnt_s=%0d done_at=%0d, want 0100 2 4 3 %0d",
               ok, g, did, mc, mcs, da, F);
    else n_pass++;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_overlap();
    test_round_robin();
    test_cross_frame();
    test_back_to_back();
    test_abort_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
